ecg_rate_timer: RTL and testbench

- Downstream consumer of the 12-bit heart-rate reload word produced by the switch-driven rate selector.
- Converts the selected reload word into a periodic sample strobe and a wrapping sample address for the ECG waveform ROM.
- Emits a beat-start pulse once per waveform period.
- Rate changes take effect only on beat boundaries, so a beat is never distorted mid-waveform.

---
 rtl/ecg_rate_timer.sv | 174 +++++++++++++++++
 tb/tb_ecg_rate_timer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecg_rate_timer.sv
// ecg_rate_timer: converts a 12-bit heart-rate reload word into a sample
// strobe, a wrapping waveform ROM address and a beat-start pulse. A new
// reload word is applied only at a beat boundary while running, or at once
// while stopped.
// Optional build macro ECG_BEAT_LED_EN adds the beat_led output.
module ecg_rate_timer #(
  parameter int unsigned PRESCALE    = 100,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned NUM_SAMPLES = 500,
  parameter int unsigned RESET_LOAD  = 3592
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [11:0]       load,
  output logic              sample_tick,
  output logic [ADDR_W-1:0] sample_addr,
  output logic              beat_start,
`ifdef ECG_BEAT_LED_EN
  output logic              beat_led,
`endif
  output logic              load_applied
);

  localparam int unsigned       PRE_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(PRESCALE - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(NUM_SAMPLES - 1);
  localparam logic [11:0]       RST_RAW    = 12'(RESET_LOAD);
  // A reload word of 0 behaves as 1, including the reset value.
  localparam logic [11:0]       RST_EFF    = (RST_RAW == 12'd0) ? 12'd1 : RST_RAW;

  logic [11:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [11:0]       pend_q, pend_d;
  logic              pend_valid_q, pend_valid_d;
  logic [11:0]       active_q, active_d;
  logic [11:0]       cnt_q, cnt_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              tick_q, tick_d;
  logic              beat_q, beat_d;
  logic              applied_q, applied_d;

  logic              stable;
  logic [11:0]       stable_eff;
  logic              pre_tick;

  // Next-state logic: capture filter, prescaler, period counter, address, rate change.
  always_comb begin
    sync1_d      = load;
    sync2_d      = sync1_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    active_d     = active_q;
    cnt_d        = cnt_q;
    pre_d        = pre_q;
    addr_d       = addr_q;
    tick_d       = 1'b0;
    beat_d       = 1'b0;
    applied_d    = 1'b0;

    stable     = (sync1_q == sync2_q);
    stable_eff = (sync2_q == 12'd0) ? 12'd1 : sync2_q;
    pre_tick   = (pre_q == PRE_LAST);

    if (en) begin
      pre_d = pre_tick ? '0 : pre_q + 1'b1;
      if (pre_tick) begin
        if (cnt_q == 12'd1) begin
          tick_d = 1'b1;
          cnt_d  = active_q;
          if (addr_q == ADDR_LAST) begin
            addr_d = '0;
            beat_d = 1'b1;
            if (pend_valid_q) begin
              active_d  = pend_q;
              cnt_d     = pend_q;
              applied_d = 1'b1;
            end
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
    end else if (pend_valid_q) begin
      active_d  = pend_q;
      cnt_d     = pend_q;
      applied_d = 1'b1;
    end

    // Compared against the post-update active value so a word captured on the
    // same edge as an apply is judged against the new rate, not the old one.
    if (stable) begin
      pend_d       = stable_eff;
      pend_valid_d = (stable_eff != active_d);
    end else if (applied_d) begin
      pend_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= RST_RAW;
      sync2_q      <= RST_RAW;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      active_q     <= RST_EFF;
      cnt_q        <= RST_EFF;
      pre_q        <= '0;
      addr_q       <= '0;
      tick_q       <= 1'b0;
      beat_q       <= 1'b0;
      applied_q    <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      active_q     <= active_d;
      cnt_q        <= cnt_d;
      pre_q        <= pre_d;
      addr_q       <= addr_d;
      tick_q       <= tick_d;
      beat_q       <= beat_d;
      applied_q    <= applied_d;
    end
  end

  assign sample_tick  = tick_q;
  assign sample_addr  = addr_q;
  assign beat_start   = beat_q;
  assign load_applied = applied_q;

`ifdef ECG_BEAT_LED_EN
  localparam int unsigned LED_HOLD = NUM_SAMPLES / 8;
  localparam int unsigned LED_W    = (LED_HOLD > 0) ? $clog2(LED_HOLD + 1) : 1;

  logic             led_q, led_d;
  logic [LED_W-1:0] led_cnt_q, led_cnt_d;

  // LED hold: (re)start on each beat, count down on the following sample ticks.
  always_comb begin
    led_d     = led_q;
    led_cnt_d = led_cnt_q;
    if (beat_d && (LED_HOLD != 0)) begin
      led_d     = 1'b1;
      led_cnt_d = LED_W'(LED_HOLD);
    end else if (tick_d && led_q) begin
      if (led_cnt_q <= LED_W'(1)) begin
        led_d     = 1'b0;
        led_cnt_d = '0;
      end else begin
        led_cnt_d = led_cnt_q - 1'b1;
      end
    end
  end

  // LED registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q     <= 1'b0;
      led_cnt_q <= '0;
    end else begin
      led_q     <= led_d;
      led_cnt_q <= led_cnt_d;
    end
  end

  assign beat_led = led_q;
`endif

endmodule

// File: tb/tb_ecg_rate_timer.sv
// Self-checking bench for ecg_rate_timer (PRESCALE=4, NUM_SAMPLES=8, ADDR_W=3).
// A countdown-of-enabled-cycles reference model is compared every cycle,
// plus literal timing pins from hand-worked sequences.
module tb_ecg_rate_timer;

  localparam int P  = 4;
  localparam int NS = 8;
  localparam int AW = 3;
  localparam int RL = 3592;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [11:0]   load;
  logic          sample_tick;
  logic [AW-1:0] sample_addr;
  logic          beat_start;
  logic          load_applied;
`ifdef ECG_BEAT_LED_EN
  logic          beat_led;
`endif

  ecg_rate_timer #(
    .PRESCALE(P), .ADDR_W(AW), .NUM_SAMPLES(NS), .RESET_LOAD(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load),
    .sample_tick(sample_tick), .sample_addr(sample_addr),
    .beat_start(beat_start),
`ifdef ECG_BEAT_LED_EN
    .beat_led(beat_led),
`endif
    .load_applied(load_applied)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks enabled cycles remaining until the next sample
  // tick, and the last two sampled load values for the stability filter.
  int m_active, m_pend, m_pv, m_addr, m_rem, m_ph, h1, h2;
  int e_tick, e_beat, e_la;
  int m_led, m_hold;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = RL; m_pend = 0; m_pv = 0; m_addr = 0;
      m_ph = 0; m_rem = P * RL; h1 = RL; h2 = RL;
      e_tick = 0; e_beat = 0; e_la = 0; m_led = 0; m_hold = 0;
    end else begin
      int eff;
      bit st;
      st  = (h1 == h2);
      eff = (h1 == 0) ? 1 : h1;
      e_tick = 0; e_beat = 0; e_la = 0;
      if (en) begin
        m_ph = (m_ph + 1) % P;
        m_rem--;
        if (m_rem == 0) begin
          e_tick = 1;
          m_addr = (m_addr + 1) % NS;
          e_beat = (m_addr == 0);
          if (e_beat && m_pv != 0) begin
            m_active = m_pend;
            e_la = 1;
          end
          m_rem = P * m_active;
        end
      end else if (m_pv != 0) begin
        m_active = m_pend;
        e_la = 1;
        m_rem = (P - m_ph) + (m_active - 1) * P;
      end
      if (st) begin
        m_pend = eff;
        m_pv = (eff != m_active);
      end else if (e_la != 0) begin
        m_pv = 0;
      end
      h2 = h1;
      h1 = int'(load);
      if (e_beat != 0) begin
        m_led = 1; m_hold = NS / 8;
      end else if (e_tick != 0 && m_led != 0) begin
        m_hold--;
        if (m_hold == 0) m_led = 0;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on && rst_n) begin
      chk("tick", int'(sample_tick), e_tick);
      chk("addr", int'(sample_addr), m_addr);
      chk("beat", int'(beat_start), e_beat);
      chk("applied", int'(load_applied), e_la);
`ifdef ECG_BEAT_LED_EN
      chk("led", int'(beat_led), m_led);
`endif
    end
  end

  function automatic bit sig(input int w);
    case (w)
      0:       return sample_tick;
      1:       return beat_start;
      default: return load_applied;
    endcase
  endfunction

  // Count negedges until the selected strobe is seen; a timeout is a failure.
  task automatic wait_sig(input int w, input int max, input string nm, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sig(w) && n < max);
    if (!sig(w)) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout actual=none required=strobe within %0d cycles", nm, max);
    end
  endtask

  initial begin
    int n, cnt, saved;
    rst_n = 1'b1; en = 1'b0; load = 12'd3;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_addr", int'(sample_addr), 0);
    chk("reset_tick", int'(sample_tick), 0);
    chk("reset_beat", int'(beat_start), 0);
    chk("reset_applied", int'(load_applied), 0);
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // Stopped apply: two sync edges, one capture edge, one apply edge.
    wait_sig(2, 10, "first_apply", n);
    chk("first_apply_latency", n, 4);

    en = 1'b1;
    wait_sig(0, 40, "first_tick", n);
    chk("first_tick_latency", n, 12);
    chk("first_tick_addr", int'(sample_addr), 1);
    for (int k = 1; k < 8; k++) begin
      wait_sig(0, 40, "tick", n);
      chk("tick_period", n, 12);
      chk("tick_addr", int'(sample_addr), (k + 1) % NS);
    end
    chk("wrap_beat", int'(beat_start), 1);
    wait_sig(1, 200, "beat", n);
    chk("beat_period", n, 96);

    // Rate change mid-beat waits for the wrap.
    repeat (2) wait_sig(0, 40, "tick", n);
    chk("pre_change_addr", int'(sample_addr), 2);
    load = 12'd5;
    for (int k = 0; k < 6; k++) begin
      wait_sig(0, 40, "tick", n);
      chk("old_rate_period", n, 12);
    end
    chk("change_wrap_addr", int'(sample_addr), 0);
    chk("change_wrap_beat", int'(beat_start), 1);
    chk("change_wrap_applied", int'(load_applied), 1);
    wait_sig(0, 40, "tick", n);
    chk("new_rate_period", n, 20);

    // Bouncing input: only the settled value is accepted.
    wait_sig(1, 400, "beat", n);
    for (int i = 0; i < 10; i++) begin
      load = (i % 2 == 0) ? 12'd3 : 12'd6;
      @(negedge clk);
    end
    load = 12'd6;
    cnt = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (load_applied) cnt++;
    end while (!beat_start && n < 400);
    chk("bounce_apply_count", cnt, 1);
    chk("bounce_apply_at_wrap", int'(load_applied), 1);
    wait_sig(0, 40, "tick", n);
    chk("bounce_rate_period", n, 24);

    // Randomised run against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (en) begin
        if ($urandom_range(39, 0) == 0) en = 1'b0;
      end else if ($urandom_range(7, 0) == 0) begin
        en = 1'b1;
      end
      if ($urandom_range(39, 0) == 0) load = 12'($urandom_range(7, 0));
      if ($urandom_range(29, 0) == 0) begin
        saved = int'(load);
        load  = 12'($urandom_range(4095, 0));
        @(negedge clk);
        load  = 12'(saved);
      end
    end

    // Zero rule while stopped.
    en = 1'b0;
    load = 12'd2;
    repeat (6) @(negedge clk);
    load = 12'd0;
    wait_sig(2, 10, "zero_apply", n);
    chk("zero_apply_latency", n, 4);
    en = 1'b1;
    wait_sig(0, 20, "zero_tick", n);
    wait_sig(0, 20, "zero_tick", n);
    chk("zero_rate_period", n, 4);
    wait_sig(0, 20, "zero_tick", n);

    // Asynchronous reset mid-beat.
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_addr", int'(sample_addr), 0);
    chk("async_reset_tick", int'(sample_tick), 0);
    chk("async_reset_beat", int'(beat_start), 0);
    chk("async_reset_applied", int'(load_applied), 0);
    load = 12'(RL);
    @(negedge clk);
    rst_n = 1'b1;
    wait_sig(0, 15000, "reset_load_tick", n);
    chk("reset_load_period", n, RL * P);

`ifdef ECG_BEAT_LED_EN
    en = 1'b0;
    load = 12'd1;
    wait_sig(2, 10, "led_apply", n);
    en = 1'b1;
    wait_sig(1, 100, "led_beat", n);
    chk("led_on_at_beat", int'(beat_led), 1);
    cnt = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (beat_led) cnt++;
    end while (beat_led && n < 50);
    chk("led_hold_cycles", cnt, 4);
`endif

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
